// File: rtl/raster_pkg.sv
// Shared FSM state type and derived-width helpers for the raster pixel source.
// Latency: n/a (types and constant functions only); backpressure: n/a.
package raster_pkg;

   typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} raster_state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Blank counter holds 0..max(H,V); kept at least 1 bit wide when both blanks are 0.
   function automatic int blank_cnt_width(input int h_blank, input int v_blank);
      return max2($clog2(max2(h_blank, v_blank) + 1), 1);
   endfunction

   function automatic int addr_width(input int cols, input int rows);
      return max2($clog2(cols * rows), 1);
   endfunction

endpackage

// File: rtl/raster_sideband_delay.sv
// ce-gated shift register that aligns pixel sidebands with the memory read latency.
// Latency: DEPTH enabled cycles; backpressure: none, ce=0 freezes every stage.
module raster_sideband_delay #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             any_valid
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (ce) begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   // The valid flag travels in the MSB of each stage.
   always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage[i][WIDTH-1];
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/raster_pixel_source.sv
// Raster-scan streamer: reads a stored frame from synchronous memory, one pixel per enabled clock.
// Latency: mem_rd to pix_valid is MEM_LATENCY enabled cycles; backpressure: none, ce=0 freezes all state.
module raster_pixel_source
   import raster_pkg::*;
#(
   parameter int IMG_COL     = 640,
   parameter int IMG_ROW     = 480,
   parameter int PIXEL_WIDTH = 8,
   parameter int H_BLANK     = 16,
   parameter int V_BLANK     = 4,
   parameter int MEM_LATENCY = 1,
   parameter int ADDR_WIDTH  = addr_width(IMG_COL, IMG_ROW),
   parameter int COORD_WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce,
   input  logic                   start,
   input  logic                   continuous,
   output logic                   mem_rd,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   input  logic [PIXEL_WIDTH-1:0] mem_data,
   output logic [PIXEL_WIDTH-1:0] pix_out,
   output logic                   pix_valid,
   output logic [COORD_WIDTH-1:0] x_coord,
   output logic [COORD_WIDTH-1:0] y_coord,
   output logic                   sof,
   output logic                   eol,
   output logic                   eof,
   output logic                   busy,
   output logic [15:0]            frame_cnt
);

   localparam int BW  = blank_cnt_width(H_BLANK, V_BLANK);
   localparam int SBW = 4 + 2 * COORD_WIDTH;

   localparam logic [COORD_WIDTH-1:0] COL_LAST = COORD_WIDTH'(IMG_COL - 1);
   localparam logic [COORD_WIDTH-1:0] ROW_LAST = COORD_WIDTH'(IMG_ROW - 1);
   localparam logic [BW-1:0]          H_LAST   = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
   localparam logic [BW-1:0]          V_LAST   = BW'((V_BLANK > 0) ? V_BLANK - 1 : 0);

   raster_state_t          state, state_n;
   logic [COORD_WIDTH-1:0] col, col_n;
   logic [COORD_WIDTH-1:0] row, row_n;
   logic [ADDR_WIDTH-1:0]  addr, addr_n;
   logic [BW-1:0]          blank_cnt, blank_n;
   logic                   frame_done;

   logic                   sof_rd, eol_rd, eof_rd;
   logic [SBW-1:0]         sb_d, sb_q;
   logic                   sb_any_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         col       <= '0;
         row       <= '0;
         addr      <= '0;
         blank_cnt <= '0;
         frame_cnt <= '0;
      end else if (ce) begin
         state     <= state_n;
         col       <= col_n;
         row       <= row_n;
         addr      <= addr_n;
         blank_cnt <= blank_n;
         if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   always_comb begin
      state_n    = state;
      col_n      = col;
      row_n      = row;
      addr_n     = addr;
      blank_n    = blank_cnt;
      frame_done = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = ACTIVE;
               col_n   = '0;
               row_n   = '0;
               addr_n  = '0;
            end
         end
         ACTIVE: begin
            // Address runs linearly through the frame, so it simply tracks row*IMG_COL+col.
            addr_n = addr + ADDR_WIDTH'(1);
            if (col == COL_LAST) begin
               if (row == ROW_LAST) begin
                  if (V_BLANK > 0) begin
                     state_n = VBLANK;
                     blank_n = '0;
                  end else begin
                     frame_done = 1'b1;
                  end
               end else if (H_BLANK > 0) begin
                  state_n = HBLANK;
                  blank_n = '0;
               end else begin
                  col_n = '0;
                  row_n = row + COORD_WIDTH'(1);
               end
            end else begin
               col_n = col + COORD_WIDTH'(1);
            end
         end
         HBLANK: begin
            if (blank_cnt == H_LAST) begin
               state_n = ACTIVE;
               col_n   = '0;
               row_n   = row + COORD_WIDTH'(1);
            end else begin
               blank_n = blank_cnt + BW'(1);
            end
         end
         VBLANK: begin
            if (blank_cnt == V_LAST) frame_done = 1'b1;
            else                     blank_n    = blank_cnt + BW'(1);
         end
         default: state_n = IDLE;
      endcase

      // End of frame: continuous is sampled here to pick loop or stop.
      if (frame_done) begin
         state_n = continuous ? ACTIVE : IDLE;
         col_n   = '0;
         row_n   = '0;
         addr_n  = '0;
      end
   end

   assign mem_rd   = (state == ACTIVE);
   assign mem_addr = addr;

   assign sof_rd = mem_rd && (col == '0) && (row == '0);
   assign eol_rd = mem_rd && (col == COL_LAST);
   assign eof_rd = eol_rd && (row == ROW_LAST);
   assign sb_d   = {mem_rd, col, row, sof_rd, eol_rd, eof_rd};

   raster_sideband_delay #(
      .DEPTH (MEM_LATENCY),
      .WIDTH (SBW)
   ) u_sideband (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .d         (sb_d),
      .q         (sb_q),
      .any_valid (sb_any_valid)
   );

   assign {pix_valid, x_coord, y_coord, sof, eol, eof} = sb_q;

   // mem_data is captured on the MEM_LATENCY-th enabled edge after its read, alongside the sidebands.
   always_ff @(posedge clk) begin
      if (rst)     pix_out <= '0;
      else if (ce) pix_out <= mem_data;
   end

   assign busy = (state != IDLE) || sb_any_valid;

endmodule

// File: tb/tb_raster_pixel_source.sv
// Bench for raster_pixel_source: three configurations checked every cycle against a
// timing/value model that derives each output from the count of enabled edges since start.
module tb_raster_pixel_source;

   localparam int A_COL = 4,   A_ROW = 3,  A_H = 2, A_V = 3, A_L = 1;
   localparam int B_COL = 4,   B_ROW = 3,  B_H = 0, B_V = 0, B_L = 2;
   localparam int C_COL = 128, C_ROW = 96, C_H = 1, C_V = 1, C_L = 4;
   localparam int AW_A = $clog2(A_COL * A_ROW);
   localparam int AW_B = $clog2(B_COL * B_ROW);
   localparam int AW_C = $clog2(C_COL * C_ROW);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       ce = 1'b1;
   logic       continuous = 1'b0;
   logic [2:0] rst_v = 3'b111;
   logic [2:0] start_v = 3'b000;
   int         mem_mul = 1;
   int         mem_seed = 0;

   logic            rd_a, pv_a, sof_a, eol_a, eof_a, busy_a;
   logic [AW_A-1:0] addr_a;
   logic [7:0]      md_a, pix_a;
   logic [9:0]      x_a, y_a;
   logic [15:0]     fc_a;

   logic            rd_b, pv_b, sof_b, eol_b, eof_b, busy_b;
   logic [AW_B-1:0] addr_b;
   logic [7:0]      md_b, pix_b;
   logic [9:0]      x_b, y_b;
   logic [15:0]     fc_b;

   logic            rd_c, pv_c, sof_c, eol_c, eof_c, busy_c;
   logic [AW_C-1:0] addr_c;
   logic [7:0]      md_c, pix_c;
   logic [9:0]      x_c, y_c;
   logic [15:0]     fc_c;

   // Memory models: combinational read for latency 1, extra registers for longer latencies.
   logic [7:0] mb0 = 8'd0;
   logic [7:0] mc0 = 8'd0, mc1 = 8'd0, mc2 = 8'd0;
   assign md_a = 8'(int'(addr_a) * mem_mul + mem_seed);
   always @(posedge clk) if (ce) mb0 <= 8'(int'(addr_b) * mem_mul + mem_seed);
   always @(posedge clk) if (ce) begin
      mc0 <= 8'(int'(addr_c) * mem_mul + mem_seed);
      mc1 <= mc0;
      mc2 <= mc1;
   end
   assign md_b = mb0;
   assign md_c = mc2;

   raster_pixel_source #(.IMG_COL(A_COL), .IMG_ROW(A_ROW), .PIXEL_WIDTH(8), .H_BLANK(A_H),
      .V_BLANK(A_V), .MEM_LATENCY(A_L), .ADDR_WIDTH(AW_A), .COORD_WIDTH(10)) dut_a (
      .clk(clk), .rst(rst_v[0]), .ce(ce), .start(start_v[0]), .continuous(continuous),
      .mem_rd(rd_a), .mem_addr(addr_a), .mem_data(md_a), .pix_out(pix_a), .pix_valid(pv_a),
      .x_coord(x_a), .y_coord(y_a), .sof(sof_a), .eol(eol_a), .eof(eof_a), .busy(busy_a),
      .frame_cnt(fc_a));

   raster_pixel_source #(.IMG_COL(B_COL), .IMG_ROW(B_ROW), .PIXEL_WIDTH(8), .H_BLANK(B_H),
      .V_BLANK(B_V), .MEM_LATENCY(B_L), .ADDR_WIDTH(AW_B), .COORD_WIDTH(10)) dut_b (
      .clk(clk), .rst(rst_v[1]), .ce(ce), .start(start_v[1]), .continuous(continuous),
      .mem_rd(rd_b), .mem_addr(addr_b), .mem_data(md_b), .pix_out(pix_b), .pix_valid(pv_b),
      .x_coord(x_b), .y_coord(y_b), .sof(sof_b), .eol(eol_b), .eof(eof_b), .busy(busy_b),
      .frame_cnt(fc_b));

   raster_pixel_source #(.IMG_COL(C_COL), .IMG_ROW(C_ROW), .PIXEL_WIDTH(8), .H_BLANK(C_H),
      .V_BLANK(C_V), .MEM_LATENCY(C_L), .ADDR_WIDTH(AW_C), .COORD_WIDTH(10)) dut_c (
      .clk(clk), .rst(rst_v[2]), .ce(ce), .start(start_v[2]), .continuous(continuous),
      .mem_rd(rd_c), .mem_addr(addr_c), .mem_data(md_c), .pix_out(pix_c), .pix_valid(pv_c),
      .x_coord(x_c), .y_coord(y_c), .sof(sof_c), .eol(eol_c), .eof(eof_c), .busy(busy_c),
      .frame_cnt(fc_c));

   int nchk = 0;
   int nfail = 0;
   int exp_fc [3];
   logic [31:0] o_rd, o_addr, o_pix, o_pv, o_x, o_y, o_sof, o_eol, o_eof, o_busy, o_fc;

   task automatic chk(input string tag, input logic [31:0] obs, input int expv);
      nchk++;
      assert (obs === 32'(expv))
      else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic sample(input int s);
      case (s)
         0: begin
            o_rd = 32'(rd_a); o_addr = 32'(addr_a); o_pix = 32'(pix_a); o_pv = 32'(pv_a);
            o_x = 32'(x_a); o_y = 32'(y_a); o_sof = 32'(sof_a); o_eol = 32'(eol_a);
            o_eof = 32'(eof_a); o_busy = 32'(busy_a); o_fc = 32'(fc_a);
         end
         1: begin
            o_rd = 32'(rd_b); o_addr = 32'(addr_b); o_pix = 32'(pix_b); o_pv = 32'(pv_b);
            o_x = 32'(x_b); o_y = 32'(y_b); o_sof = 32'(sof_b); o_eol = 32'(eol_b);
            o_eof = 32'(eof_b); o_busy = 32'(busy_b); o_fc = 32'(fc_b);
         end
         default: begin
            o_rd = 32'(rd_c); o_addr = 32'(addr_c); o_pix = 32'(pix_c); o_pv = 32'(pv_c);
            o_x = 32'(x_c); o_y = 32'(y_c); o_sof = 32'(sof_c); o_eol = 32'(eol_c);
            o_eof = 32'(eof_c); o_busy = 32'(busy_c); o_fc = 32'(fc_c);
         end
      endcase
   endtask

   task automatic chk_zero(input int s);
      sample(s);
      chk("rst_mem_rd", o_rd, 0);
      chk("rst_mem_addr", o_addr, 0);
      chk("rst_pix_valid", o_pv, 0);
      chk("rst_pix_out", o_pix, 0);
      chk("rst_xy", o_x | o_y, 0);
      chk("rst_markers", o_sof | o_eol | o_eof, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_frame_cnt", o_fc, 0);
   endtask

   // Which pixel (if any) is read in enabled cycle u of a run of nfr frames.
   function automatic bit pix_at(input int u, input int c, input int r, input int h,
                                 input int v, input int nfr, output int x, output int y);
      int p, q, w;
      q = c + h;
      p = r * c + (r - 1) * h + v;
      x = 0;
      y = 0;
      if (u < 0 || u >= nfr * p) return 1'b0;
      w = u % p;
      if (w >= p - v) return 1'b0;
      y = w / q;
      x = w % q;
      return (x < c);
   endfunction

   // ce_mode: 0 always on, 1 pattern 1,0,0,1, 2 random.
   task automatic run(input int s, input int nfr, input int ce_mode, input bit again, input bit do_rst);
      int c, r, h, v, l, p, q, e, t_last, cyc, budget, base, x, y, rx, ry, nf;
      bit v_exp, r_exp, again_done;
      case (s)
         0:       begin c = A_COL; r = A_ROW; h = A_H; v = A_V; l = A_L; end
         1:       begin c = B_COL; r = B_ROW; h = B_H; v = B_V; l = B_L; end
         default: begin c = C_COL; r = C_ROW; h = C_H; v = C_V; l = C_L; end
      endcase
      q = c + h;
      p = r * c + (r - 1) * h + v;
      t_last = (nfr - 1) * p + (r - 1) * q + c - 1;
      budget = 4 * (t_last + l + 8);
      base = exp_fc[s];
      continuous = (nfr > 1);
      ce = 1'b1;
      start_v[s] = 1'b1;
      @(posedge clk); #1;
      start_v[s] = 1'b0;
      e = 0;
      cyc = 0;
      again_done = 1'b0;
      while (e <= t_last + l + 2 && cyc < budget) begin
         sample(s);
         r_exp = pix_at(e, c, r, h, v, nfr, rx, ry);
         chk("mem_rd", o_rd, int'(r_exp));
         if (r_exp) chk("mem_addr", o_addr, ry * c + rx);
         v_exp = pix_at(e - l, c, r, h, v, nfr, x, y);
         chk("pix_valid", o_pv, int'(v_exp));
         if (v_exp) begin
            chk("x_coord", o_x, x);
            chk("y_coord", o_y, y);
            chk("pix_out", o_pix, (( y * c + x) * mem_mul + mem_seed) & 255);
         end
         chk("sof", o_sof, int'(v_exp && x == 0 && y == 0));
         chk("eol", o_eol, int'(v_exp && x == c - 1));
         chk("eof", o_eof, int'(v_exp && x == c - 1 && y == r - 1));
         nf = (e / p < nfr) ? e / p : nfr;
         chk("frame_cnt", o_fc, (base + nf) & 16'hFFFF);
         chk("busy", o_busy, int'((e < nfr * p) || (e <= t_last + l)));
         if (do_rst && v_exp && x == 2 && y == 1) begin
            start_v[s] = 1'b0;
            rst_v[s] = 1'b1;
            ce = 1'b1;
            @(posedge clk); #1;
            rst_v[s] = 1'b0;
            chk_zero(s);
            exp_fc[s] = 0;
            return;
         end
         if (again && !again_done && e >= 5) begin
            start_v[s] = 1'b1;
            again_done = 1'b1;
         end else begin
            start_v[s] = 1'b0;
         end
         if (e >= (nfr - 1) * p) continuous = 1'b0;
         case (ce_mode)
            0:       ce = 1'b1;
            1:       ce = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: ce = ($urandom_range(0, 3) != 0);
         endcase
         @(posedge clk); #1;
         if (ce) e++;
         cyc++;
      end
      chk("run_completed", int'(e > t_last + l + 2), 1);
      exp_fc[s] = (base + nfr) & 16'hFFFF;
   endtask

   initial begin
      exp_fc = '{0, 0, 0};
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) chk_zero(s);
      rst_v = 3'b000;

      run(0, 1, 0, 1'b0, 1'b0);   // basic frame, memory value = address
      run(0, 1, 1, 1'b0, 1'b0);   // ce pattern 1,0,0,1
      mem_mul = 2 * $urandom_range(0, 60) + 1;
      mem_seed = $urandom_range(0, 255);
      run(0, 1, 2, 1'b0, 1'b0);   // random ce, random memory
      run(0, 2, 2, 1'b1, 1'b0);   // start ignored while busy, continuous dropped in frame 2
      run(0, 1, 0, 1'b0, 1'b1);   // reset at pixel (2,1)
      run(0, 1, 2, 1'b0, 1'b0);   // clean frame after reset

      mem_mul = 1;
      mem_seed = 0;
      run(1, 3, 0, 1'b0, 1'b0);   // continuous, zero blanking, latency 2
      mem_mul = 2 * $urandom_range(0, 60) + 1;
      mem_seed = $urandom_range(0, 255);
      run(1, 2, 2, 1'b0, 1'b0);
      run(2, 1, 0, 1'b0, 1'b0);   // large frame, latency 4

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
      $finish;
   end

endmodule
